ex_mem_stage_reg: RTL and testbench
===================================

Name: ex_mem_stage_reg

Overview:
- EX/MEM pipeline boundary register for the 5-stage RV32I core.
- Captures EX-stage results and drives the data-memory request.
- Aligns load/store data and produces the MEM-stage signals consumed by the EX operand forwarding logic: mem_rd, mem_RegWEn, mem_MemRead, mem_alu_out, mem_load_data.
- Stalls the front of the pipe while a data-memory access is outstanding.

Parameters:
- PERF_CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  core clock
- rst_n  in  1  reset, asynchronous, active-low
- ex_valid  in  1  EX holds a real instruction
- ex_rd  in  5  destination register
- ex_RegWEn  in  1  instruction writes rd
- ex_MemRead  in  1  load
- ex_MemWrite  in  1  store
- ex_funct3  in  3  load/store size and sign (000 B, 001 H, 010 W, 100 BU, 101 HU)
- ex_alu_out  in  32  ALU result / effective address
- ex_rs2_data  in  32  store data, already forwarded
- flush  in  1  insert bubble instead of capturing EX
- dm_req  out  1  data-memory request
- dm_we  out  1  write enable
- dm_addr  out  32  word address, {mem_alu_out[31:2],2'b00}
- dm_wdata  out  32  lane-aligned store data
- dm_bwe  out  4  byte write enables
- dm_rdata  in  32  read data, valid when dm_ready
- dm_ready  in  1  access complete this cycle
- mem_stall  out  1  hold PC/IF/ID/EX this cycle
- mem_valid  out  1  MEM holds a real instruction
- mem_rd  out  5
- mem_RegWEn  out  1  = reg_RegWEn & mem_valid
- mem_MemRead  out  1  = reg_MemRead & mem_valid
- mem_alu_out  out  32
- mem_load_data  out  32  aligned, extended load result

Behaviour:
- Reset (async, rst_n=0):
  - all registered fields 0, state=RUN.
  - Outputs: mem_valid=0, mem_RegWEn=0, mem_MemRead=0, dm_req=0, mem_stall=0, perf counters 0.
- FSM states RUN and WAIT.
- dm_req = mem_valid & (MemRead|MemWrite); asserted in both states while the access is unfinished.
- mem_stall = dm_req & ~dm_ready (combinational).
- Transitions:
  - RUN -> WAIT when mem_stall=1.
  - WAIT -> RUN on the cycle dm_ready=1; mem_stall drops that same cycle.
- Capture, on a clk edge with mem_stall=0:
  - flush=1: mem_valid<=0 and control bits <=0 (bubble); data fields don't-care.
  - else: load all ex_* fields; mem_valid<=ex_valid.
- When mem_stall=1, all fields hold and flush is ignored. Upstream keeps flush asserted because EX is also frozen.
- Latency:
  - Non-memory op: 1 cycle EX->MEM.
  - Memory op: 1 + number of cycles until dm_ready.
  - Zero-wait memory (dm_ready same cycle as dm_req) produces no stall.
- Store alignment, off = mem_alu_out[1:0]:
  - SB: dm_wdata = {4{rs2[7:0]}}, dm_bwe = 4'b0001<<off.
  - SH: dm_wdata = {2{rs2[15:0]}}, dm_bwe = 4'b0011<<{off[1],1'b0}.
  - SW: dm_wdata = rs2, dm_bwe = 4'b1111.
  - dm_we = MemWrite. dm_bwe = 0 when not a store.
- Load extraction: byte/half selected by off, then sign- or zero-extended per funct3. mem_load_data is combinational from dm_rdata.
- Misaligned half/word: off bits ignored (forced aligned); no trap.
- Illegal funct3 on a memory op: treated as W.

Optional Feature:
- Macro EXMEM_PERF_CNT_EN.
- When defined, adds outputs perf_stall_cnt and perf_mem_ops (PERF_CNT_W each).
  - perf_stall_cnt increments every cycle mem_stall=1.
  - perf_mem_ops increments on each cycle dm_req & dm_ready.
  - Both saturate at all-ones and reset to 0.
- When undefined, neither the ports nor the logic exist.

Test Plan:
1. ADD x5 (ex_rd=5, RegWEn=1, alu_out=0x10): next cycle mem_valid=1, mem_rd=5, mem_RegWEn=1, mem_MemRead=0, dm_req=0, mem_stall=0.
2. LW, alu_out=0x104, dm_ready held low 3 cycles: mem_stall=1 for exactly 3 cycles; dm_addr=0x104; ex_* changes ignored during the stall. dm_rdata=0xDEADBEEF with ready gives mem_load_data=0xDEADBEEF and state returns to RUN.
3. LB off=3, dm_rdata=0x80xxxxxx: mem_load_data=0xFFFFFF80. LBU gives 0x00000080. LH off=2, rdata=0x8001xxxx: 0xFFFF8001.
4. SB, alu_out=0x202, rs2=0x000000AB: dm_wdata=0xABABABAB, dm_bwe=4'b0100, dm_we=1. SH at off=2: dm_bwe=4'b1100.
5. flush=1 with ex_valid=1, ex_RegWEn=1: next cycle mem_valid=0 and mem_RegWEn=0. flush during a stall leaves the held LW intact.
6. rst_n pulled low mid-WAIT: outputs go to 0 immediately (async), state=RUN. After release, the first captured op behaves as in scenario 1.

Source files
------------

// File: rtl/ex_mem_stage_reg.sv
// ============================================================================
// Module   : ex_mem_stage_reg
// Purpose  : EX/MEM pipeline register for the 5-stage RV32I core. Captures EX
//            results, issues the data-memory request, aligns store data and
//            load results, and stalls the front of the pipe while a data
//            access is outstanding.
// Options  : EXMEM_PERF_CNT_EN adds saturating stall / memory-op counters.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_mem_stage_reg #(
  parameter int PERF_CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid_i,
  input  logic [4:0]            ex_rd_i,
  input  logic                  ex_RegWEn_i,
  input  logic                  ex_MemRead_i,
  input  logic                  ex_MemWrite_i,
  input  logic [2:0]            ex_funct3_i,
  input  logic [31:0]           ex_alu_out_i,
  input  logic [31:0]           ex_rs2_data_i,
  input  logic                  flush_i,
  output logic                  dm_req_o,
  output logic                  dm_we_o,
  output logic [31:0]           dm_addr_o,
  output logic [31:0]           dm_wdata_o,
  output logic [3:0]            dm_bwe_o,
  input  logic [31:0]           dm_rdata_i,
  input  logic                  dm_ready_i,
  output logic                  mem_stall_o,
  output logic                  mem_valid_o,
  output logic [4:0]            mem_rd_o,
  output logic                  mem_RegWEn_o,
  output logic                  mem_MemRead_o,
  output logic [31:0]           mem_alu_out_o,
  output logic [31:0]           mem_load_data_o
`ifdef EXMEM_PERF_CNT_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stall_cnt_o,
  output logic [PERF_CNT_W-1:0] perf_mem_ops_o
`endif
);

  localparam logic [0:0] ST_RUN  = 1'b0;
  localparam logic [0:0] ST_WAIT = 1'b1;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  logic [0:0]  state_q, state_d;
  logic        valid_q;
  logic [4:0]  rd_q;
  logic        regwen_q;
  logic        memread_q;
  logic        memwrite_q;
  logic [2:0]  funct3_q;
  logic [31:0] alu_q;
  logic [31:0] rs2_q;

  logic [1:0]  off;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  assign off = alu_q[1:0];

  // Pipeline register: frozen while an access is outstanding, bubble on flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      rd_q       <= 5'd0;
      regwen_q   <= 1'b0;
      memread_q  <= 1'b0;
      memwrite_q <= 1'b0;
      funct3_q   <= 3'd0;
      alu_q      <= 32'd0;
      rs2_q      <= 32'd0;
    end else if (!mem_stall_o) begin
      // Data fields are don't-care in a bubble, so they load unconditionally.
      rd_q     <= ex_rd_i;
      funct3_q <= ex_funct3_i;
      alu_q    <= ex_alu_out_i;
      rs2_q    <= ex_rs2_data_i;
      if (flush_i) begin
        valid_q    <= 1'b0;
        regwen_q   <= 1'b0;
        memread_q  <= 1'b0;
        memwrite_q <= 1'b0;
      end else begin
        valid_q    <= ex_valid_i;
        regwen_q   <= ex_RegWEn_i;
        memread_q  <= ex_MemRead_i;
        memwrite_q <= ex_MemWrite_i;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state: enter WAIT when an access stalls, leave when it completes.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN:  if (mem_stall_o) state_d = ST_WAIT;
      ST_WAIT: if (!mem_stall_o) state_d = ST_RUN;
      default: state_d = ST_RUN;
    endcase
  end

  // FSM / pipeline outputs: request, stall and forwarding-visible fields.
  always_comb begin
    mem_valid_o   = valid_q;
    mem_rd_o      = rd_q;
    mem_RegWEn_o  = regwen_q & valid_q;
    mem_MemRead_o = memread_q & valid_q;
    mem_alu_out_o = alu_q;
    dm_req_o      = valid_q & (memread_q | memwrite_q);
    dm_we_o       = valid_q & memwrite_q;
    dm_addr_o     = {alu_q[31:2], 2'b00};
    mem_stall_o   = dm_req_o & ~dm_ready_i;
  end

  // Store lane replication and byte enables; misaligned H/W forced aligned.
  always_comb begin
    dm_wdata_o = rs2_q;
    dm_bwe_o   = 4'b0000;
    if (dm_we_o) begin
      case (funct3_q)
        F3_B: begin
          dm_wdata_o = {4{rs2_q[7:0]}};
          dm_bwe_o   = 4'b0001 << off;
        end
        F3_H: begin
          dm_wdata_o = {2{rs2_q[15:0]}};
          dm_bwe_o   = 4'b0011 << {off[1], 1'b0};
        end
        default: begin
          dm_wdata_o = rs2_q;
          dm_bwe_o   = 4'b1111;
        end
      endcase
    end
  end

  // Load lane extraction and sign/zero extension, straight from dm_rdata.
  always_comb begin
    case (off)
      2'd0:    ld_byte = dm_rdata_i[7:0];
      2'd1:    ld_byte = dm_rdata_i[15:8];
      2'd2:    ld_byte = dm_rdata_i[23:16];
      default: ld_byte = dm_rdata_i[31:24];
    endcase
    ld_half = off[1] ? dm_rdata_i[31:16] : dm_rdata_i[15:0];
    case (funct3_q)
      F3_B:    mem_load_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_BU:   mem_load_data_o = {24'd0, ld_byte};
      F3_H:    mem_load_data_o = {{16{ld_half[15]}}, ld_half};
      F3_HU:   mem_load_data_o = {16'd0, ld_half};
      default: mem_load_data_o = dm_rdata_i;
    endcase
  end

`ifdef EXMEM_PERF_CNT_EN
  logic [PERF_CNT_W-1:0] stall_cnt_q;
  logic [PERF_CNT_W-1:0] memop_cnt_q;
  localparam logic [PERF_CNT_W-1:0] CNT_ONE = {{(PERF_CNT_W-1){1'b0}}, 1'b1};

  // Saturating performance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      memop_cnt_q <= '0;
    end else begin
      if (mem_stall_o && !(&stall_cnt_q)) begin
        stall_cnt_q <= stall_cnt_q + CNT_ONE;
      end
      if (dm_req_o && dm_ready_i && !(&memop_cnt_q)) begin
        memop_cnt_q <= memop_cnt_q + CNT_ONE;
      end
    end
  end

  assign perf_stall_cnt_o = stall_cnt_q;
  assign perf_mem_ops_o   = memop_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ex_mem_stage_reg.sv
// ============================================================================
// Module   : tb_ex_mem_stage_reg
// Purpose  : Self-checking bench for ex_mem_stage_reg using an expectation
//            queue filled at issue time and drained when MEM presents output.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_RegWEn, ex_MemRead, ex_MemWrite, flush;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_alu_out, ex_rs2_data;
  logic        dm_req, dm_we, dm_ready, mem_stall, mem_valid;
  logic        mem_RegWEn, mem_MemRead;
  logic [31:0] dm_addr, dm_wdata, dm_rdata, mem_alu_out, mem_load_data;
  logic [3:0]  dm_bwe;
  logic [4:0]  mem_rd;
`ifdef EXMEM_PERF_CNT_EN
  logic [31:0] perf_stall_cnt, perf_mem_ops;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int exp_stalls = 0;
  int exp_memops = 0;

  typedef struct {
    logic        valid, regwen, memread, we, req;
    logic [4:0]  rd;
    logic [31:0] alu, wdata, load, rdata;
    logic [3:0]  bwe;
    int          wait_n;
  } exp_t;

  exp_t sb[$];

  ex_mem_stage_reg #(.PERF_CNT_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ex_valid_i      (ex_valid),
    .ex_rd_i         (ex_rd),
    .ex_RegWEn_i     (ex_RegWEn),
    .ex_MemRead_i    (ex_MemRead),
    .ex_MemWrite_i   (ex_MemWrite),
    .ex_funct3_i     (ex_funct3),
    .ex_alu_out_i    (ex_alu_out),
    .ex_rs2_data_i   (ex_rs2_data),
    .flush_i         (flush),
    .dm_req_o        (dm_req),
    .dm_we_o         (dm_we),
    .dm_addr_o       (dm_addr),
    .dm_wdata_o      (dm_wdata),
    .dm_bwe_o        (dm_bwe),
    .dm_rdata_i      (dm_rdata),
    .dm_ready_i      (dm_ready),
    .mem_stall_o     (mem_stall),
    .mem_valid_o     (mem_valid),
    .mem_rd_o        (mem_rd),
    .mem_RegWEn_o    (mem_RegWEn),
    .mem_MemRead_o   (mem_MemRead),
    .mem_alu_out_o   (mem_alu_out),
    .mem_load_data_o (mem_load_data)
`ifdef EXMEM_PERF_CNT_EN
    ,
    .perf_stall_cnt_o(perf_stall_cnt),
    .perf_mem_ops_o  (perf_mem_ops)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic drive_ex(input logic v, input logic [4:0] rd, input logic rw,
                          input logic mr, input logic mw, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rs2, input logic fl);
    ex_valid = v; ex_rd = rd; ex_RegWEn = rw; ex_MemRead = mr; ex_MemWrite = mw;
    ex_funct3 = f3; ex_alu_out = alu; ex_rs2_data = rs2; flush = fl;
  endtask

  // Non-memory filler presented to EX while MEM is busy; must never reach MEM early.
  task automatic drive_junk(input logic fl);
    drive_ex(1'b1, 5'd31, 1'b1, 1'b0, 1'b0, 3'b000, 32'hFFFF_FFF0, 32'h5555_5555, fl);
  endtask

  task automatic run_op(input string tag, input logic v, input logic [4:0] rd,
                        input logic rw, input logic mr, input logic mw, input logic [2:0] f3,
                        input logic [31:0] alu, input logic [31:0] rs2, input logic fl,
                        input int wait_n, input logic [31:0] rdata, input logic [31:0] exp_load,
                        input logic [31:0] exp_wdata, input logic [3:0] exp_bwe,
                        input logic junk_flush);
    exp_t e;
    e.valid   = v & ~fl;
    e.regwen  = rw & e.valid;
    e.memread = mr & e.valid;
    e.we      = mw & e.valid;
    e.req     = e.memread | e.we;
    e.rd      = rd;
    e.alu     = alu;
    e.wdata   = exp_wdata;
    e.bwe     = exp_bwe;
    e.load    = exp_load;
    e.rdata   = rdata;
    e.wait_n  = wait_n;
    drive_ex(v, rd, rw, mr, mw, f3, alu, rs2, fl);
    sb.push_back(e);
    @(posedge clk); #1;
    drive_junk(junk_flush);
    e = sb.pop_front();
    check({tag, ".valid"},   {31'd0, mem_valid},   {31'd0, e.valid});
    check({tag, ".regwen"},  {31'd0, mem_RegWEn},  {31'd0, e.regwen});
    check({tag, ".memread"}, {31'd0, mem_MemRead}, {31'd0, e.memread});
    check({tag, ".req"},     {31'd0, dm_req},      {31'd0, e.req});
    check({tag, ".we"},      {31'd0, dm_we},       {31'd0, e.we});
    check({tag, ".bwe"},     {28'd0, dm_bwe},      {28'd0, e.bwe});
    if (e.valid) begin
      check({tag, ".rd"},   {27'd0, mem_rd}, {27'd0, e.rd});
      check({tag, ".alu"},  mem_alu_out, e.alu);
      check({tag, ".addr"}, dm_addr, {e.alu[31:2], 2'b00});
    end
    if (e.we) check({tag, ".wdata"}, dm_wdata, e.wdata);
    if (e.req) begin
      for (int k = 0; k < e.wait_n; k++) begin
        check({tag, ".stall"},   {31'd0, mem_stall}, 32'd1);
        check({tag, ".hold_rd"}, {27'd0, mem_rd}, {27'd0, e.rd});
        check({tag, ".hold_alu"}, mem_alu_out, e.alu);
        @(posedge clk); #1;
        check({tag, ".st_wait"}, {31'd0, dut.state_q}, 32'd1);
      end
      dm_ready = 1'b1;
      dm_rdata = e.rdata;
      #1;
      check({tag, ".stall_rel"}, {31'd0, mem_stall}, 32'd0);
      if (e.memread) check({tag, ".load"}, mem_load_data, e.load);
      exp_stalls += e.wait_n;
      exp_memops += 1;
      @(posedge clk); #1;
      dm_ready = 1'b0;
      check({tag, ".st_run"}, {31'd0, dut.state_q}, 32'd0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dm_ready = 1'b0;
    dm_rdata = 32'd0;
    drive_ex(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 3'b000, 32'd0, 32'd0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst.valid",   {31'd0, mem_valid},   32'd0);
    check("rst.regwen",  {31'd0, mem_RegWEn},  32'd0);
    check("rst.memread", {31'd0, mem_MemRead}, 32'd0);
    check("rst.req",     {31'd0, dm_req},      32'd0);
    check("rst.stall",   {31'd0, mem_stall},   32'd0);
    rst_n = 1'b1;

    // Asynchronous reset while waiting on a load.
    drive_ex(1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'd0, 1'b0);
    @(posedge clk); #1;
    drive_junk(1'b0);
    check("arst.pre_stall", {31'd0, mem_stall}, 32'd1);
    @(posedge clk); #1;
    check("arst.pre_wait", {31'd0, dut.state_q}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("arst.valid",  {31'd0, mem_valid},  32'd0);
    check("arst.regwen", {31'd0, mem_RegWEn}, 32'd0);
    check("arst.req",    {31'd0, dm_req},     32'd0);
    check("arst.stall",  {31'd0, mem_stall},  32'd0);
    check("arst.state",  {31'd0, dut.state_q}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    //      tag        v  rd     rw  mr  mw  f3      alu            rs2            fl  wt rdata          load           wdata          bwe     jf
    run_op("add",      1, 5'd5,  1,  0,  0,  3'b000, 32'h0000_0010, 32'd0,         0,  0, 32'd0,         32'd0,         32'd0,         4'b0000, 0);
    run_op("lw",       1, 5'd6,  1,  1,  0,  3'b010, 32'h0000_0104, 32'd0,         0,  3, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'd0,         4'b0000, 0);
    run_op("lw_fl",    1, 5'd8,  1,  1,  0,  3'b010, 32'h0000_0108, 32'd0,         0,  2, 32'h0BAD_F00D, 32'h0BAD_F00D, 32'd0,         4'b0000, 1);
    run_op("lb",       1, 5'd10, 1,  1,  0,  3'b000, 32'h0000_0103, 32'd0,         0,  1, 32'h8012_3456, 32'hFFFF_FF80, 32'd0,         4'b0000, 0);
    run_op("lbu",      1, 5'd11, 1,  1,  0,  3'b100, 32'h0000_0103, 32'd0,         0,  0, 32'h8012_3456, 32'h0000_0080, 32'd0,         4'b0000, 0);
    run_op("lb1",      1, 5'd12, 1,  1,  0,  3'b000, 32'h0000_0101, 32'd0,         0,  0, 32'h0000_7F00, 32'h0000_007F, 32'd0,         4'b0000, 0);
    run_op("lh",       1, 5'd13, 1,  1,  0,  3'b001, 32'h0000_0102, 32'd0,         0,  0, 32'h8001_1234, 32'hFFFF_8001, 32'd0,         4'b0000, 0);
    run_op("lhu",      1, 5'd14, 1,  1,  0,  3'b101, 32'h0000_0100, 32'd0,         0,  0, 32'h1234_ABCD, 32'h0000_ABCD, 32'd0,         4'b0000, 0);
    run_op("lw_mis",   1, 5'd15, 1,  1,  0,  3'b010, 32'h0000_0107, 32'd0,         0,  1, 32'hCAFE_F00D, 32'hCAFE_F00D, 32'd0,         4'b0000, 0);
    run_op("ld_ill",   1, 5'd16, 1,  1,  0,  3'b011, 32'h0000_0108, 32'd0,         0,  0, 32'h89AB_CDEF, 32'h89AB_CDEF, 32'd0,         4'b0000, 0);
    run_op("sb",       1, 5'd0,  0,  0,  1,  3'b000, 32'h0000_0202, 32'h0000_00AB, 0,  2, 32'd0,         32'd0,         32'hABAB_ABAB, 4'b0100, 0);
    run_op("sb0",      1, 5'd0,  0,  0,  1,  3'b000, 32'h0000_0200, 32'h1234_56FF, 0,  0, 32'd0,         32'd0,         32'hFFFF_FFFF, 4'b0001, 0);
    run_op("sh",       1, 5'd0,  0,  0,  1,  3'b001, 32'h0000_0202, 32'h1234_CDEF, 0,  0, 32'd0,         32'd0,         32'hCDEF_CDEF, 4'b1100, 0);
    run_op("sh_mis",   1, 5'd0,  0,  0,  1,  3'b001, 32'h0000_0203, 32'h0000_5A5A, 0,  1, 32'd0,         32'd0,         32'h5A5A_5A5A, 4'b1100, 0);
    run_op("sw",       1, 5'd0,  0,  0,  1,  3'b010, 32'h0000_0200, 32'h1122_3344, 0,  0, 32'd0,         32'd0,         32'h1122_3344, 4'b1111, 0);
    run_op("flush",    1, 5'd7,  1,  0,  0,  3'b000, 32'h0000_0040, 32'd0,         1,  0, 32'd0,         32'd0,         32'd0,         4'b0000, 0);
    run_op("flush_ld", 1, 5'd7,  1,  1,  0,  3'b010, 32'h0000_0044, 32'd0,         1,  0, 32'd0,         32'd0,         32'd0,         4'b0000, 0);
    run_op("bubble",   0, 5'd3,  1,  0,  0,  3'b000, 32'h0000_0050, 32'd0,         0,  0, 32'd0,         32'd0,         32'd0,         4'b0000, 0);
    run_op("add2",     1, 5'd5,  1,  0,  0,  3'b000, 32'h0000_0010, 32'd0,         0,  0, 32'd0,         32'd0,         32'd0,         4'b0000, 0);

`ifdef EXMEM_PERF_CNT_EN
    check("perf.stalls", perf_stall_cnt, exp_stalls);
    check("perf.memops", perf_mem_ops,   exp_memops);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Bound the run in case the design deadlocks.
  initial begin
    #200000;
    n_errors++;
    $display("FAIL timeout: got no completion expected completion before 200000ns");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
